// File: rtl/mbutton_scan.sv
// mbutton_scan
//   Scanner for a multiplexed push-button matrix. The shared return line
//   (pbin) and the mux drive lines (muxin) are synchronised. Each rising
//   edge of a drive line takes one return sample for its button. Every
//   button has an N-consecutive-sample debounce filter. The block reports
//   debounced levels, press/release events and a one-shot long-press event.
//
// Parameters
//   MUX_NOB     number of drive lines / buttons (>= 2)
//   DEB_SAMPLES consecutive disagreeing samples needed to flip a level (>= 1)
//   LONG_SCANS  full scans held before long_press fires (0 disables it)
//
// Ports
//   clk         clock, rising edge
//   reset_n     asynchronous active-low reset
//   muxin       mux drive lines, active high, nominally one-hot
//   pbin        muxed button return line, active high
//   buttons     debounced button levels
//   pressed     1-cycle pulse on a debounced 0->1 transition
//   released    1-cycle pulse on a debounced 1->0 transition
//   long_press  1-cycle pulse once a button has been held LONG_SCANS scans
//   scan_tick   1-cycle pulse per full scan (the muxin[0] sample)
module mbutton_scan #(
    parameter int MUX_NOB     = 6,
    parameter int DEB_SAMPLES = 3,
    parameter int LONG_SCANS  = 250
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [MUX_NOB-1:0] muxin,
    input  logic               pbin,
    output logic [MUX_NOB-1:0] buttons,
    output logic [MUX_NOB-1:0] pressed,
    output logic [MUX_NOB-1:0] released,
    output logic [MUX_NOB-1:0] long_press,
    output logic               scan_tick
);

    localparam int CW = (DEB_SAMPLES > 1) ? $clog2(DEB_SAMPLES) : 1;
    localparam int LW = (LONG_SCANS > 0) ? $clog2(LONG_SCANS + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_SAMPLES - 1);

    logic [2:0]         pb_sync;
    logic               pbin_s2;
    logic [MUX_NOB-1:0] mux_s0;
    logic [MUX_NOB-1:0] mux_s1;
    logic [MUX_NOB-1:0] rise_r;
    logic [MUX_NOB-1:0] sample_en;
    logic [CW-1:0]      cnt [MUX_NOB];

    // pbin gets one more stage than muxin so that the sample used at the
    // debounce update is the return value captured when the line rose.
    assign pbin_s2 = pb_sync[2];

    // Drive line k samples button (k-1) mod MUX_NOB: rotate rise_r right.
    assign sample_en = {rise_r[0], rise_r[MUX_NOB-1:1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pb_sync   <= '0;
            mux_s0    <= '0;
            mux_s1    <= '0;
            rise_r    <= '0;
            scan_tick <= 1'b0;
        end else begin
            pb_sync   <= {pb_sync[1:0], pbin};
            mux_s0    <= muxin;
            mux_s1    <= mux_s0;
            rise_r    <= mux_s0 & ~mux_s1;
            scan_tick <= rise_r[0];
        end
    end

    // Debounce: a sample agreeing with the current level clears the run of
    // disagreeing samples; DEB_SAMPLES disagreeing samples in a row flip it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buttons  <= '0;
            pressed  <= '0;
            released <= '0;
            for (int unsigned i = 0; i < MUX_NOB; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            pressed  <= '0;
            released <= '0;
            for (int unsigned i = 0; i < MUX_NOB; i++) begin
                if (sample_en[i]) begin
                    if (pbin_s2 == buttons[i]) begin
                        cnt[i] <= '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        buttons[i]  <= pbin_s2;
                        cnt[i]      <= '0;
                        pressed[i]  <= pbin_s2;
                        released[i] <= ~pbin_s2;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    generate
        if (LONG_SCANS == 0) begin : g_no_long
            assign long_press = '0;
        end else begin : g_long
            localparam logic [LW-1:0] L_MAX = LW'(LONG_SCANS);
            logic [LW-1:0] lcnt [MUX_NOB];

            // Counts scans on the pre-update level, so a button that rises on
            // the same edge as scan_tick is not yet counted for that scan.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    long_press <= '0;
                    for (int unsigned i = 0; i < MUX_NOB; i++) begin
                        lcnt[i] <= '0;
                    end
                end else begin
                    long_press <= '0;
                    for (int unsigned i = 0; i < MUX_NOB; i++) begin
                        if (!buttons[i]) begin
                            lcnt[i] <= '0;
                        end else if (rise_r[0] && (lcnt[i] != L_MAX)) begin
                            lcnt[i] <= lcnt[i] + 1'b1;
                            if (lcnt[i] == L_MAX - 1'b1) begin
                                long_press[i] <= 1'b1;
                            end
                        end
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_mbutton_scan.sv
// tb_mbutton_scan
//   Two instances share the stimulus: dut_a (6 buttons, 3-sample debounce,
//   long press after 4 scans) and dut_b (6 buttons, no filtering, long press
//   disabled). A behavioural model predicts every output.
module tb_mbutton_scan;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] muxin = '0;
    logic       pbin = 1'b0;

    logic [5:0] btn_a, pr_a, rl_a, lp_a;
    logic       st_a;
    logic [5:0] btn_b, pr_b, rl_b, lp_b;
    logic       st_b;

    mbutton_scan #(.MUX_NOB(6), .DEB_SAMPLES(3), .LONG_SCANS(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .muxin(muxin), .pbin(pbin),
        .buttons(btn_a), .pressed(pr_a), .released(rl_a),
        .long_press(lp_a), .scan_tick(st_a)
    );

    mbutton_scan #(.MUX_NOB(6), .DEB_SAMPLES(1), .LONG_SCANS(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .muxin(muxin), .pbin(pbin),
        .buttons(btn_b), .pressed(pr_b), .released(rl_b),
        .long_press(lp_b), .scan_tick(st_b)
    );

    always #5 clk = ~clk;

    // Observed output vector: per DUT {buttons, pressed, released, long_press, scan_tick}
    logic [49:0] obs;
    assign obs = {btn_a, pr_a, rl_a, lp_a, st_a, btn_b, pr_b, rl_b, lp_b, st_b};

    int errors = 0;
    int checks = 0;

    // Reference model state
    int         deb_n  [2] = '{3, 1};
    int         long_n [2] = '{4, 0};
    logic [5:0] m_btn  [2];
    int         m_dis  [2][6];
    int         m_lc   [2][6];

    logic [49:0] ex_pre, ex_upd, ex_post;
    logic [49:0] ob_pre, ob_upd, ob_post;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_btn[d] = '0;
            for (int i = 0; i < 6; i++) begin
                m_dis[d][i] = 0;
                m_lc[d][i]  = 0;
            end
        end
    endtask

    // One sampling event: every line in mask rises while pbin = v.
    task automatic model_step(input logic [5:0] mask, input logic v);
        logic [5:0]  old_b, pr, rl, lp;
        logic [24:0] pre [2];
        logic [24:0] upd [2];
        logic [24:0] post [2];
        int          b;
        for (int d = 0; d < 2; d++) begin
            old_b = m_btn[d];
            pr = '0; rl = '0; lp = '0;
            // scans held are judged on the level before this event
            for (int i = 0; i < 6; i++) begin
                if (!old_b[i]) begin
                    m_lc[d][i] = 0;
                end else if (mask[0] && long_n[d] > 0 && m_lc[d][i] < long_n[d]) begin
                    m_lc[d][i]++;
                    if (m_lc[d][i] == long_n[d]) lp[i] = 1'b1;
                end
            end
            for (int k = 0; k < 6; k++) begin
                if (mask[k]) begin
                    b = (k + 5) % 6;
                    if (v == m_btn[d][b]) begin
                        m_dis[d][b] = 0;
                    end else begin
                        m_dis[d][b]++;
                        if (m_dis[d][b] == deb_n[d]) begin
                            m_btn[d][b] = v;
                            m_dis[d][b] = 0;
                            pr[b] = v;
                            rl[b] = ~v;
                        end
                    end
                end
            end
            for (int i = 0; i < 6; i++) begin
                if (!m_btn[d][i]) m_lc[d][i] = 0;
            end
            pre[d]  = {old_b, 19'b0};
            upd[d]  = {m_btn[d], pr, rl, lp, mask[0]};
            post[d] = {m_btn[d], 19'b0};
        end
        ex_pre  = {pre[0], pre[1]};
        ex_upd  = {upd[0], upd[1]};
        ex_post = {post[0], post[1]};
    endtask

    // Drive one sampling event and capture outputs one cycle before, at, and
    // one cycle after the expected update (third edge after muxin rises).
    task automatic apply_step(input logic [5:0] mask, input logic v);
        model_step(mask, v);
        @(posedge clk); #1 pbin = v;
        @(posedge clk); #1 muxin = mask;
        @(posedge clk);
        @(posedge clk); #1 ob_pre = obs; muxin = '0;
        @(posedge clk); #1 ob_upd = obs;
        @(posedge clk); #1 ob_post = obs;
    endtask

    task automatic do_reset();
        @(posedge clk); #2 reset_n = 1'b0;
        muxin = '0;
        @(posedge clk);
        @(posedge clk); #2 reset_n = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        model_reset();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk); #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_hold got=%h want=%h", obs, 50'h0);
        end
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_release got=%h want=%h", obs, 50'h0);
        end
    endtask

    task automatic test_bounce();
        logic sv [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int n = 0; n < 5; n++) begin
            apply_step(6'b001000, sv[n]);
            checks += 3;
            if (ob_pre !== ex_pre) begin errors++; $display("FAIL bounce[%0d] pre got=%h want=%h", n, ob_pre, ex_pre); end
            if (ob_upd !== ex_upd) begin errors++; $display("FAIL bounce[%0d] upd got=%h want=%h", n, ob_upd, ex_upd); end
            if (ob_post !== ex_post) begin errors++; $display("FAIL bounce[%0d] post got=%h want=%h", n, ob_post, ex_post); end
        end
        checks++;
        if (ob_upd[49:38] !== 12'b000100_000100) begin
            errors++;
            $display("FAIL bounce_press_a got=%b want=%b", ob_upd[49:38], 12'b000100_000100);
        end
    endtask

    task automatic test_release();
        logic sv [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int n = 0; n < 6; n++) begin
            apply_step(6'b001000, sv[n]);
            checks += 3;
            if (ob_pre !== ex_pre) begin errors++; $display("FAIL release[%0d] pre got=%h want=%h", n, ob_pre, ex_pre); end
            if (ob_upd !== ex_upd) begin errors++; $display("FAIL release[%0d] upd got=%h want=%h", n, ob_upd, ex_upd); end
            if (ob_post !== ex_post) begin errors++; $display("FAIL release[%0d] post got=%h want=%h", n, ob_post, ex_post); end
        end
        checks++;
        if (ob_upd[49:32] !== 18'b000000_000000_000100) begin
            errors++;
            $display("FAIL release_event_a got=%b want=%b", ob_upd[49:32], 18'b000000_000000_000100);
        end
    endtask

    task automatic test_mapping();
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < 6; k++) begin
                apply_step(6'(1 << k), (k == 0));
                checks += 3;
                if (ob_pre !== ex_pre) begin errors++; $display("FAIL mapping[%0d.%0d] pre got=%h want=%h", s, k, ob_pre, ex_pre); end
                if (ob_upd !== ex_upd) begin errors++; $display("FAIL mapping[%0d.%0d] upd got=%h want=%h", s, k, ob_upd, ex_upd); end
                if (ob_post !== ex_post) begin errors++; $display("FAIL mapping[%0d.%0d] post got=%h want=%h", s, k, ob_post, ex_post); end
            end
        end
        checks++;
        if (ob_post[49:44] !== 6'b100000) begin
            errors++;
            $display("FAIL mapping_levels_a got=%b want=%b", ob_post[49:44], 6'b100000);
        end
    endtask

    task automatic test_long_press();
        int lp_seen = 0;
        int plan [3] = '{10, 4, 10};
        for (int ph = 0; ph < 3; ph++) begin
            for (int s = 0; s < plan[ph]; s++) begin
                for (int k = 0; k < 6; k++) begin
                    apply_step(6'(1 << k), (k == 1) && (ph != 1));
                    if (ob_upd[26]) lp_seen++;
                    checks += 3;
                    if (ob_pre !== ex_pre) begin errors++; $display("FAIL long[%0d.%0d.%0d] pre got=%h want=%h", ph, s, k, ob_pre, ex_pre); end
                    if (ob_upd !== ex_upd) begin errors++; $display("FAIL long[%0d.%0d.%0d] upd got=%h want=%h", ph, s, k, ob_upd, ex_upd); end
                    if (ob_post !== ex_post) begin errors++; $display("FAIL long[%0d.%0d.%0d] post got=%h want=%h", ph, s, k, ob_post, ex_post); end
                end
            end
        end
        checks++;
        if (lp_seen != 2) begin
            errors++;
            $display("FAIL long_press_count got=%0d want=%0d", lp_seen, 2);
        end
    endtask

    task automatic test_async_reset();
        // build a partial count on button 1, then reset with a sample pending
        apply_step(6'b000100, 1'b1);
        apply_step(6'b000100, 1'b1);
        @(posedge clk); #1 pbin = 1'b1;
        @(posedge clk); #1 muxin = 6'b000100;
        @(posedge clk);
        @(posedge clk); #3 reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL async_reset got=%h want=%h", obs, 50'h0);
        end
        muxin = '0;
        @(posedge clk);
        @(posedge clk); #2 reset_n = 1'b1;
        model_reset();
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL after_reset got=%h want=%h", obs, 50'h0);
        end
        for (int n = 0; n < 3; n++) begin
            apply_step(6'b000100, 1'b1);
            checks += 3;
            if (ob_pre !== ex_pre) begin errors++; $display("FAIL requalify[%0d] pre got=%h want=%h", n, ob_pre, ex_pre); end
            if (ob_upd !== ex_upd) begin errors++; $display("FAIL requalify[%0d] upd got=%h want=%h", n, ob_upd, ex_upd); end
            if (ob_post !== ex_post) begin errors++; $display("FAIL requalify[%0d] post got=%h want=%h", n, ob_post, ex_post); end
        end
    endtask

    task automatic test_non_one_hot();
        do_reset();
        apply_step(6'b000110, 1'b1);
        checks += 4;
        if (ob_pre !== ex_pre) begin errors++; $display("FAIL multi pre got=%h want=%h", ob_pre, ex_pre); end
        if (ob_upd !== ex_upd) begin errors++; $display("FAIL multi upd got=%h want=%h", ob_upd, ex_upd); end
        if (ob_post !== ex_post) begin errors++; $display("FAIL multi post got=%h want=%h", ob_post, ex_post); end
        if (ob_upd[24:13] !== 12'b000011_000011) begin
            errors++;
            $display("FAIL multi_press_b got=%b want=%b", ob_upd[24:13], 12'b000011_000011);
        end
    endtask

    task automatic test_random();
        logic [5:0] tgt = '0;
        logic [5:0] mask;
        int         k, b;
        logic       v;
        for (int n = 0; n < 150; n++) begin
            k = $urandom_range(0, 5);
            mask = 6'(1 << k);
            if ($urandom_range(0, 7) == 0) mask[$urandom_range(0, 5)] = 1'b1;
            b = (k + 5) % 6;
            if ($urandom_range(0, 9) == 0) tgt[b] = ~tgt[b];
            v = tgt[b];
            if ($urandom_range(0, 6) == 0) v = ~v;
            apply_step(mask, v);
            checks += 3;
            if (ob_pre !== ex_pre) begin errors++; $display("FAIL random[%0d] pre got=%h want=%h", n, ob_pre, ex_pre); end
            if (ob_upd !== ex_upd) begin errors++; $display("FAIL random[%0d] upd got=%h want=%h", n, ob_upd, ex_upd); end
            if (ob_post !== ex_post) begin errors++; $display("FAIL random[%0d] post got=%h want=%h", n, ob_post, ex_post); end
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_release();
        test_mapping();
        test_long_press();
        test_async_reset();
        test_non_one_hot();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
